// File: rtl/logo_pixel_pipe_if.sv
// Pixel-side bundle between the logo locator, the logo ROM, the pixel pipe and the colour mapper.
// Strobe semantics: there is no ready; every input is sampled only on a Clk where pixel_en=1
// (frame_start on its own Clk), and every output holds its value until the next strobe.
interface logo_pixel_pipe_if;
    logic        pixel_en;
    logic        frame_start;
    logic [1:0]  RoomNum;
    logic        is_logo;
    logic [15:0] logo_address;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic        logo_valid;
    logic [23:0] logo_rgb;

    modport slave (
        input  pixel_en, frame_start, RoomNum, is_logo, logo_address, rom_data,
        output rom_addr, logo_valid, logo_rgb
    );

    modport master (
        output pixel_en, frame_start, RoomNum, is_logo, logo_address, rom_data,
        input  rom_addr, logo_valid, logo_rgb
    );
endinterface

// File: rtl/logo_pixel_pipe.sv
// Two-stage logo pixel pipeline (ROM fetch, palette + brightness) with a frame-synchronous
// fade envelope driven by the start-screen room.
module logo_pixel_pipe #(
    parameter int FADE_FRAMES = 4,
    parameter bit FADE_EN     = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    logo_pixel_pipe_if.slave  bus,
    output logic [1:0]        dbg_state,
    output logic [4:0]        dbg_level
);

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    localparam logic [7:0] CNT_LAST  = 8'(FADE_FRAMES - 1);
    // The frame that starts a ramp already counts as its first frame.
    localparam logic [7:0] CNT_ENTRY = (FADE_FRAMES > 1) ? 8'd1 : 8'd0;
    localparam logic [4:0] LEVEL_MAX = 5'd16;

    fade_state_t state, state_nxt;
    logic [4:0]  level, level_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        home;

    logic        v1;
    logic [23:0] pal_rgb;
    logic [23:0] scaled_rgb;
    logic        vis;

    assign home      = (bus.RoomNum == 2'd0);
    assign dbg_state = state;
    assign dbg_level = level;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= HIDDEN;
            level <= 5'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        cnt_nxt   = cnt;
        if (bus.frame_start) begin
            case (state)
                HIDDEN: begin
                    if (home) begin
                        state_nxt = FADE_IN;
                        cnt_nxt   = CNT_ENTRY;
                    end
                end
                FADE_IN: begin
                    if (!home) begin
                        state_nxt = FADE_OUT;
                        cnt_nxt   = CNT_ENTRY;
                    end else if (!FADE_EN) begin
                        state_nxt = SHOWN;
                        level_nxt = LEVEL_MAX;
                        cnt_nxt   = 8'd0;
                    end else if (cnt >= CNT_LAST) begin
                        cnt_nxt = 8'd0;
                        if (level < LEVEL_MAX) level_nxt = level + 5'd1;
                        if (level >= LEVEL_MAX - 5'd1) state_nxt = SHOWN;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                SHOWN: begin
                    if (!home) begin
                        state_nxt = FADE_OUT;
                        cnt_nxt   = CNT_ENTRY;
                    end
                end
                FADE_OUT: begin
                    if (home) begin
                        state_nxt = FADE_IN;
                        cnt_nxt   = CNT_ENTRY;
                    end else if (!FADE_EN) begin
                        state_nxt = HIDDEN;
                        level_nxt = 5'd0;
                        cnt_nxt   = 8'd0;
                    end else if (cnt >= CNT_LAST) begin
                        cnt_nxt = 8'd0;
                        if (level > 5'd0) level_nxt = level - 5'd1;
                        if (level <= 5'd1) state_nxt = HIDDEN;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                default: state_nxt = HIDDEN;
            endcase
        end
    end

    always_comb begin
        pal_rgb = 24'hFF00FF;
        case (bus.rom_data)
            4'd0: pal_rgb = 24'h000000;
            4'd1: pal_rgb = 24'hFFFFFF;
            4'd2: pal_rgb = 24'h000000;
            4'd3: pal_rgb = 24'hB13425;
            4'd4: pal_rgb = 24'h6A6B04;
            default: pal_rgb = 24'hFF00FF;
        endcase
    end

    // 8x5 product held in 13 bits; bits [11:4] are the faded channel.
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [4:0] lvl);
        logic [12:0] prod;
        prod = 13'(ch) * 13'(lvl);
        return 8'(prod >> 4);
    endfunction

    assign scaled_rgb = {scale_ch(pal_rgb[23:16], level),
                         scale_ch(pal_rgb[15:8],  level),
                         scale_ch(pal_rgb[7:0],   level)};
    assign vis = v1 && (bus.rom_data != 4'd0) && (level != 5'd0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bus.rom_addr   <= 16'd0;
            v1             <= 1'b0;
            bus.logo_valid <= 1'b0;
            bus.logo_rgb   <= 24'd0;
        end else if (bus.pixel_en) begin
            bus.rom_addr   <= bus.is_logo ? bus.logo_address : 16'd0;
            v1             <= bus.is_logo;
            bus.logo_valid <= vis;
            bus.logo_rgb   <= vis ? scaled_rgb : 24'd0;
        end
    end

endmodule

// File: tb/tb_logo_pixel_pipe.sv
// Bench for logo_pixel_pipe: synchronous ROM model, fade schedule checks and a pixel scoreboard.
module tb_logo_pixel_pipe;

    logic       Clk;
    logic       Reset;
    logic [1:0] dbg_state;
    logic [4:0] dbg_level;

    logo_pixel_pipe_if bus ();

    logo_pixel_pipe #(.FADE_FRAMES(4), .FADE_EN(1'b1)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus.master),
        .dbg_state (dbg_state),
        .dbg_level (dbg_level)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Synchronous ROM: data valid one Clk after the address.
    logic [3:0] rom_mem [64];
    always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr[5:0]];

    // ---------------- scoreboard ----------------
    logic [24:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_pixel(input logic il, input logic [15:0] addr, input logic [24:0] exp);
        logic [24:0] e;
        @(posedge Clk); #1;
        bus.is_logo      = il;
        bus.logo_address = addr;
        bus.pixel_en     = 1'b1;
        @(posedge Clk); #1;
        bus.pixel_en = 1'b0;
        check("rom_addr", 32'(bus.rom_addr), il ? 32'(addr) : 32'd0);
        exp_q.push_back(exp);
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("pixel", 32'({bus.logo_valid, bus.logo_rgb}), 32'(e));
        end
    endtask

    task automatic start_stream();
        exp_q.delete();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            bus.frame_start = 1'b1;
            @(posedge Clk); #1;
            bus.frame_start = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge Clk);
        end
    endtask

    task automatic check_fade(input string tag, input logic [4:0] lvl, input logic [1:0] st);
        check({tag, "_level"}, 32'(dbg_level), 32'(lvl));
        check({tag, "_state"}, 32'(dbg_state), 32'(st));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 4'(i % 16);
        rom_mem[0]  = 4'd3;
        rom_mem[1]  = 4'd0;
        rom_mem[2]  = 4'd2;
        rom_mem[10] = 4'd1;
        rom_mem[11] = 4'd3;

        Reset            = 1'b0;
        bus.pixel_en     = 1'b0;
        bus.frame_start  = 1'b0;
        bus.RoomNum      = 2'd0;
        bus.is_logo      = 1'b1;
        bus.logo_address = 16'd10;

        // Reset held for 3 Clk with pixels strobing.
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            bus.pixel_en = ~bus.pixel_en;
            @(negedge Clk);
            check("rst_valid", 32'(bus.logo_valid), 32'd0);
            check("rst_rgb", 32'(bus.logo_rgb), 32'd0);
            check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        end
        @(posedge Clk); #1;
        bus.pixel_en = 1'b0;
        Reset = 1'b1;
        check_fade("after_rst", 5'd0, 2'd0);

        // Level 0: logo pixels stay invisible.
        start_stream();
        drive_pixel(1'b1, 16'd10, 25'h0);
        drive_pixel(1'b1, 16'd10, 25'h0);
        drive_pixel(1'b0, 16'd0, 25'h0);

        // Fade in: level 1 after the 4th pulse, 16 after the 64th.
        frames(3);
        check_fade("fin3", 5'd0, 2'd1);
        frames(1);
        check_fade("fin4", 5'd1, 2'd1);
        frames(59);
        check_fade("fin63", 5'd15, 2'd1);
        frames(1);
        check_fade("fin64", 5'd16, 2'd2);

        start_stream();
        drive_pixel(1'b1, 16'd10, {1'b1, 24'hFFFFFF});
        drive_pixel(1'b0, 16'd0, 25'h0);

        // ROM returns 3,0,2 for addresses 0,1,2.
        start_stream();
        drive_pixel(1'b1, 16'd0, {1'b1, 24'hB13425});
        drive_pixel(1'b1, 16'd1, {1'b0, 24'h000000});
        drive_pixel(1'b1, 16'd2, {1'b1, 24'h000000});
        drive_pixel(1'b0, 16'd0, 25'h0);

        // Fade out one level every 4 pulses.
        bus.RoomNum = 2'd1;
        frames(3);
        check_fade("fout3", 5'd16, 2'd3);
        frames(1);
        check_fade("fout4", 5'd15, 2'd3);
        frames(4);
        check_fade("fout8", 5'd14, 2'd3);
        frames(16);
        check_fade("fout24", 5'd10, 2'd3);

        // Back to the start screen: resume upward from 10.
        bus.RoomNum = 2'd0;
        frames(3);
        check_fade("resume3", 5'd10, 2'd1);
        frames(1);
        check_fade("resume4", 5'd11, 2'd1);

        bus.RoomNum = 2'd2;
        frames(4);
        check_fade("fout_b4", 5'd10, 2'd3);
        frames(8);
        check_fade("fout_b12", 5'd8, 2'd3);

        // Half brightness.
        start_stream();
        drive_pixel(1'b1, 16'd10, {1'b1, 24'h7F7F7F});
        drive_pixel(1'b1, 16'd11, {1'b1, 24'h581A12});
        drive_pixel(1'b0, 16'd10, 25'h0);

        // pixel_en low: outputs hold.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("hold", 32'({bus.logo_valid, bus.logo_rgb}), 32'({1'b1, 24'h581A12}));
        end
        drive_pixel(1'b0, 16'd10, 25'h0);
        drive_pixel(1'b0, 16'd10, 25'h0);

        // Reset mid-operation, then a fresh fade from 0.
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_fade("mid_rst", 5'd0, 2'd0);
        check("mid_rst_valid", 32'(bus.logo_valid), 32'd0);
        check("mid_rst_rom", 32'(bus.rom_addr), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        bus.RoomNum = 2'd0;
        frames(1);
        check_fade("fresh1", 5'd0, 2'd1);
        frames(3);
        check_fade("fresh4", 5'd1, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/logo_pixel_pipe.md
Name: logo_pixel_pipe

Overview:
- Downstream consumer of the logo locator's is_logo / logo_address pair.
- Issues reads to the synchronous logo palette-index ROM and resolves each index through a 16-entry palette.
- Applies a frame-synchronous fade-in/fade-out brightness envelope tied to the start-screen room.
- Presents a pixel-aligned logo_valid / logo_rgb pair to the color mapper for priority muxing against background and sprites.

Parameters:
- FADE_FRAMES, 4: frames per brightness step; legal range 1..255.
- FADE_EN, 1: when 0, brightness jumps directly between 0 and 16 with no ramp.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-low reset.
- pixel_en  in  1  one-Clk strobe per pixel (25 MHz rate); the pipeline advances only on it.
- frame_start  in  1  one-Clk pulse at start of vertical blanking.
- RoomNum  in  2  current level; 0 = start screen.
- is_logo  in  1  current DrawX/DrawY lies inside the logo box.
- logo_address  in  16  ROM address for the current pixel.
- rom_addr  out  16  address to the logo ROM.
- rom_data  in  4  palette index from the ROM, valid one Clk after rom_addr changes.
- logo_valid  out  1  current output pixel is opaque logo.
- logo_rgb  out  24  {R,G,B} 8 bits each, faded.

Behaviour:
- Reset (asynchronous, Reset=0):
  - rom_addr=0, logo_valid=0, logo_rgb=0.
  - Pipeline valid bits = 0.
  - Fade state = HIDDEN, level = 0, frame counter = 0.
- Pipeline: two stages, both advancing only on pixel_en. Total latency is 2 pixel_en strobes from is_logo/logo_address to logo_valid/logo_rgb. Outputs hold between strobes.
- S1, on pixel_en:
  - rom_addr <= logo_address when is_logo=1, else 0.
  - v1 <= is_logo.
- S2, on pixel_en:
  - idx = rom_data (stable, since rom_addr was held for at least 1 Clk).
  - logo_valid <= v1 & (idx != 0) & (level != 0).
  - logo_rgb <= per-channel (palette[idx] channel × level) >> 4, computed with an 8×5 → 13-bit product keeping bits [11:4].
  - level=16 passes colours exactly; level=0 forces logo_rgb = 0.
  - logo_rgb = 0 whenever logo_valid would be 0.
- Palette:
  - idx 0 = transparent.
  - 1 = FFFFFF.
  - 2 = 000000.
  - 3 = B13425.
  - 4 = 6A6B04.
  - 5..15 = FF00FF (debug magenta) until the art set is finalised.
- Fade FSM: evaluated only on frame_start cycles. level is 5 bits, 0..16, and changes only on frame_start, so it is constant within a visible frame (no tearing).
  - HIDDEN: RoomNum==0 → FADE_IN, frame counter cleared.
  - FADE_IN:
    - RoomNum!=0 → FADE_OUT.
    - Otherwise, counter increments; at FADE_FRAMES-1 the counter clears and level += 1.
    - Level reaching 16 → SHOWN.
  - SHOWN: RoomNum!=0 → FADE_OUT, counter cleared.
  - FADE_OUT:
    - RoomNum==0 → FADE_IN, continuing from the current level.
    - Otherwise, step as FADE_IN but level -= 1.
    - Level reaching 0 → HIDDEN.
  - FADE_EN=0: FADE_IN sets level=16 → SHOWN; FADE_OUT sets level=0 → HIDDEN; each on the same frame_start.
  - Level saturates at 0 and at 16; it never wraps.
- Simultaneous events:
  - frame_start coincident with pixel_en: S2 uses the pre-update level; the new level applies from the next strobe.
  - RoomNum changing away from 0 mid-frame has no effect until the next frame_start.
- Reset mid-operation: everything returns to reset values immediately. The first frame_start after release with RoomNum==0 begins a fresh fade from 0.
- pixel_en held low: pipeline frozen; the FSM still runs on frame_start.

Test Plan:
- Reset low for 3 Clk with is_logo=1 and RoomNum=0 → logo_valid=0, logo_rgb=0, rom_addr=0 throughout; after release and before any frame_start, logo_valid stays 0 (level=0).
- FADE_EN=1, FADE_FRAMES=4, RoomNum=0, frame_start pulses → level 1 after the 4th pulse, 16 after the 64th pulse, state SHOWN; with rom_data=1 in view → logo_rgb=FFFFFF, logo_valid=1.
- At level 16, stream logo_address 0,1,2 with is_logo=1 and the ROM returning 3,0,2 → after 2 pixel_en strobes: (valid=1, B13425), then (valid=0, 000000), then (valid=1, 000000); rom_addr tracks the addresses one strobe earlier.
- At level 8, rom_data=1 → logo_rgb=7F7F7F; rom_data=3 → 581A12.
- From SHOWN, set RoomNum=1 → level decrements every 4 frame_starts. At level 10, set RoomNum=0 → the next step is level 11 (FADE_IN resumes from 10, no reset to 0).
- is_logo=0 with rom_data=1 → logo_valid=0 and rom_addr=0. With pixel_en=0 for 10 Clk, logo_valid/logo_rgb hold their prior values.
